// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Drives the instruction-memory address from the PC
// and reads one 16-bit word per cycle. Single-word instructions go straight
// into the IF/ID register. LDM is two words long: its opcode word is parked in
// hold registers while the immediate word is fetched, and the assembled
// instruction is presented one cycle later.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   imem_addr          instruction memory address (the PC)
//   imem_data          instruction word at imem_addr (combinational read)
//   stall              freeze PC, FSM, hold registers and IF/ID
//   redirect           reload PC from redirect_pc and flush (beats stall)
//   redirect_pc        redirect target
//   op_code, rsrc,
//   rdst, imm          IF/ID instruction fields (imm is non-zero only for LDM)
//   pc_out             address of the first word of the presented instruction
//   if_valid           IF/ID holds a real instruction
module fetch_unit #(
  parameter int                 ADDR_W   = 12,
  parameter int                 DATA_W   = 16,
  parameter int                 OP_W     = 5,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [OP_W-1:0]    OP_LDM   = 5'b00001,
  parameter logic [OP_W-1:0]    OP_NOP   = 5'b00101
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [OP_W-1:0]   op_code,
  output logic [2:0]        rsrc,
  output logic [2:0]        rdst,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              if_valid
);

  typedef enum logic {FETCH, FETCH_IMM} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [OP_W-1:0]   hold_op, hold_op_next;
  logic [2:0]        hold_rsrc, hold_rsrc_next;
  logic [2:0]        hold_rdst, hold_rdst_next;
  logic [ADDR_W-1:0] hold_pc, hold_pc_next;
  logic [OP_W-1:0]   op_code_next;
  logic [2:0]        rsrc_next, rdst_next;
  logic [DATA_W-1:0] imm_next;
  logic [ADDR_W-1:0] pc_out_next;
  logic              if_valid_next;

  logic [OP_W-1:0]   word_op;
  logic [2:0]        word_rsrc, word_rdst;
  logic [ADDR_W-1:0] pc_inc;

  assign imem_addr = pc;
  assign word_op   = imem_data[DATA_W-1 -: OP_W];
  assign word_rsrc = imem_data[DATA_W-OP_W-1 -: 3];
  assign word_rdst = imem_data[DATA_W-OP_W-4 -: 3];
  // Natural wrap at the top of the address space: an LDM in the last word
  // takes its immediate from address 0.
  assign pc_inc    = pc + ADDR_W'(1);

  // Next-state logic. Everything defaults to "hold", which is exactly what a
  // stall needs. Redirect is checked first so it overrides both stall and
  // any half-fetched LDM.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    hold_op_next   = hold_op;
    hold_rsrc_next = hold_rsrc;
    hold_rdst_next = hold_rdst;
    hold_pc_next   = hold_pc;
    op_code_next   = op_code;
    rsrc_next      = rsrc;
    rdst_next      = rdst;
    imm_next       = imm;
    pc_out_next    = pc_out;
    if_valid_next  = if_valid;

    if (redirect) begin
      state_next     = FETCH;
      pc_next        = redirect_pc;
      hold_op_next   = '0;
      hold_rsrc_next = '0;
      hold_rdst_next = '0;
      hold_pc_next   = '0;
      op_code_next   = OP_NOP;
      rsrc_next      = '0;
      rdst_next      = '0;
      imm_next       = '0;
      if_valid_next  = 1'b0;
    end else if (!stall) begin
      pc_next = pc_inc;
      case (state)
        FETCH: begin
          if (word_op == OP_LDM) begin
            // Park the opcode word and put a bubble on IF/ID while the
            // immediate is fetched.
            state_next     = FETCH_IMM;
            hold_op_next   = word_op;
            hold_rsrc_next = word_rsrc;
            hold_rdst_next = word_rdst;
            hold_pc_next   = pc;
            op_code_next   = OP_NOP;
            rsrc_next      = '0;
            rdst_next      = '0;
            imm_next       = '0;
            if_valid_next  = 1'b0;
          end else begin
            op_code_next  = word_op;
            rsrc_next     = word_rsrc;
            rdst_next     = word_rdst;
            imm_next      = '0;
            pc_out_next   = pc;
            if_valid_next = 1'b1;
          end
        end
        FETCH_IMM: begin
          state_next    = FETCH;
          op_code_next  = hold_op;
          rsrc_next     = hold_rsrc;
          rdst_next     = hold_rdst;
          imm_next      = imem_data;
          pc_out_next   = hold_pc;
          if_valid_next = 1'b1;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // State, PC, hold and IF/ID registers. Reset aborts any in-flight LDM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_op   <= '0;
      hold_rsrc <= '0;
      hold_rdst <= '0;
      hold_pc   <= '0;
      op_code   <= OP_NOP;
      rsrc      <= '0;
      rdst      <= '0;
      imm       <= '0;
      pc_out    <= '0;
      if_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      hold_op   <= hold_op_next;
      hold_rsrc <= hold_rsrc_next;
      hold_rdst <= hold_rdst_next;
      hold_pc   <= hold_pc_next;
      op_code   <= op_code_next;
      rsrc      <= rsrc_next;
      rdst      <= rdst_next;
      imm       <= imm_next;
      pc_out    <= pc_out_next;
      if_valid  <= if_valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. Instance A uses a 12-bit PC with reset
// address 0x010; instance B uses a 4-bit PC to exercise address wrap.
// Both instruction memories are combinational arrays owned by the bench.
module tb_fetch_unit;

  localparam logic [4:0] NOP = 5'b00101;
  localparam logic [4:0] LDM = 5'b00001;
  localparam logic [4:0] NOT = 5'b00100;
  localparam logic [4:0] ADD = 5'b00010;

  logic        clk = 1'b0;
  logic        rst, rst_b;

  logic [11:0] imem_addr_a, redirect_pc_a, pc_out_a;
  logic [15:0] imem_data_a, imm_a;
  logic        stall_a, redirect_a, if_valid_a;
  logic [4:0]  op_code_a;
  logic [2:0]  rsrc_a, rdst_a;

  logic [3:0]  imem_addr_b, redirect_pc_b, pc_out_b;
  logic [15:0] imem_data_b, imm_b;
  logic        stall_b, redirect_b, if_valid_b;
  logic [4:0]  op_code_b;
  logic [2:0]  rsrc_b, rdst_b;

  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:15];

  int errors = 0;
  int checks = 0;

  assign imem_data_a = mem_a[imem_addr_a];
  assign imem_data_b = mem_b[imem_addr_b];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h010)) u_a (
    .clk(clk), .rst(rst), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .stall(stall_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
    .op_code(op_code_a), .rsrc(rsrc_a), .rdst(rdst_a), .imm(imm_a),
    .pc_out(pc_out_a), .if_valid(if_valid_a)
  );

  fetch_unit #(.ADDR_W(4)) u_b (
    .clk(clk), .rst(rst_b), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .op_code(op_code_b), .rsrc(rsrc_b), .rdst(rdst_b), .imm(imm_b),
    .pc_out(pc_out_b), .if_valid(if_valid_b)
  );

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive instance A's control inputs, then advance one clock and settle.
  task automatic applyStimulus(input logic st, input logic rd, input logic [11:0] rp);
    stall_a       = st;
    redirect_a    = rd;
    redirect_pc_a = rp;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_a[i] = 16'h2800;
    for (int i = 0; i < 16; i++) mem_b[i] = 16'h2800;
    mem_a[12'h010] = 16'h2000;
    mem_a[12'h011] = 16'h0920;
    mem_a[12'h012] = 16'hBEEF;
    for (int k = 0; k < 4; k++)
      mem_a[12'h013 + k] = {ADD, 3'(k), 3'(k + 1), 5'b0};
    mem_a[12'h017] = 16'h0A40;
    mem_a[12'h018] = 16'h5555;
    mem_a[12'h040] = 16'h3160;
    mem_a[12'h005] = 16'h2000;
    mem_a[12'h006] = 16'hF8E0;
    mem_a[12'h007] = 16'h0920;
    mem_a[12'h008] = 16'h7777;
    mem_b[4'hF]    = 16'h0920;
    mem_b[4'h0]    = 16'h1234;

    rst = 1'b1; rst_b = 1'b1;
    stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = '0;
    stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_addr",   32'(imem_addr_a), 32'h010);
    checkOutput("rst_op",     32'(op_code_a),   32'(NOP));
    checkOutput("rst_valid",  32'(if_valid_a),  0);
    checkOutput("rst_imm",    32'(imm_a),       0);
    checkOutput("rst_pc_out", 32'(pc_out_a),    0);
    rst = 1'b0;

    // First instruction after reset: NOT at 0x010
    applyStimulus(0, 0, '0);
    checkOutput("not_op",    32'(op_code_a),   32'(NOT));
    checkOutput("not_valid", 32'(if_valid_a),  1);
    checkOutput("not_pc",    32'(pc_out_a),    32'h010);
    checkOutput("not_addr",  32'(imem_addr_a), 32'h011);

    // LDM at 0x011 with immediate 0xBEEF: one bubble then the instruction
    applyStimulus(0, 0, '0);
    checkOutput("ldm_bub_valid", 32'(if_valid_a),  0);
    checkOutput("ldm_bub_op",    32'(op_code_a),   32'(NOP));
    checkOutput("ldm_bub_addr",  32'(imem_addr_a), 32'h012);
    applyStimulus(0, 0, '0);
    checkOutput("ldm_op",    32'(op_code_a),   32'(LDM));
    checkOutput("ldm_rsrc",  32'(rsrc_a),      1);
    checkOutput("ldm_rdst",  32'(rdst_a),      1);
    checkOutput("ldm_imm",   32'(imm_a),       32'hBEEF);
    checkOutput("ldm_pc",    32'(pc_out_a),    32'h011);
    checkOutput("ldm_valid", 32'(if_valid_a),  1);
    checkOutput("ldm_addr",  32'(imem_addr_a), 32'h013);

    // ADD stream with a 3-cycle stall after the second ADD
    applyStimulus(0, 0, '0);
    checkOutput("add0_pc",   32'(pc_out_a), 32'h013);
    checkOutput("add0_rdst", 32'(rdst_a),   1);
    checkOutput("add0_imm",  32'(imm_a),    0);
    applyStimulus(0, 0, '0);
    checkOutput("add1_pc",   32'(pc_out_a), 32'h014);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1, 0, '0);
      checkOutput("stall_op",    32'(op_code_a),   32'(ADD));
      checkOutput("stall_rsrc",  32'(rsrc_a),      1);
      checkOutput("stall_rdst",  32'(rdst_a),      2);
      checkOutput("stall_pc",    32'(pc_out_a),    32'h014);
      checkOutput("stall_valid", 32'(if_valid_a),  1);
      checkOutput("stall_addr",  32'(imem_addr_a), 32'h015);
    end
    applyStimulus(0, 0, '0);
    checkOutput("add2_pc",   32'(pc_out_a), 32'h015);
    checkOutput("add2_rsrc", 32'(rsrc_a),   2);
    applyStimulus(0, 0, '0);
    checkOutput("add3_pc",   32'(pc_out_a), 32'h016);
    checkOutput("add3_rdst", 32'(rdst_a),   4);

    // LDM at 0x017, redirected to 0x040 while fetching its immediate
    applyStimulus(0, 0, '0);
    checkOutput("ldm2_bub_valid", 32'(if_valid_a),  0);
    checkOutput("ldm2_addr",      32'(imem_addr_a), 32'h018);
    applyStimulus(0, 1, 12'h040);
    checkOutput("redir_valid", 32'(if_valid_a),  0);
    checkOutput("redir_op",    32'(op_code_a),   32'(NOP));
    checkOutput("redir_addr",  32'(imem_addr_a), 32'h040);
    applyStimulus(0, 0, '0);
    checkOutput("tgt_op",    32'(op_code_a),  32'h06);
    checkOutput("tgt_pc",    32'(pc_out_a),   32'h040);
    checkOutput("tgt_rdst",  32'(rdst_a),     3);
    checkOutput("tgt_valid", 32'(if_valid_a), 1);

    // Redirect and stall together: redirect wins
    applyStimulus(1, 1, 12'h005);
    checkOutput("rs_addr",  32'(imem_addr_a), 32'h005);
    checkOutput("rs_valid", 32'(if_valid_a),  0);
    checkOutput("rs_op",    32'(op_code_a),   32'(NOP));
    applyStimulus(0, 0, '0);
    checkOutput("rs_next_op", 32'(op_code_a), 32'(NOT));
    checkOutput("rs_next_pc", 32'(pc_out_a),  32'h005);

    // Undefined opcode passes through as a single-word instruction
    applyStimulus(0, 0, '0);
    checkOutput("unk_op",    32'(op_code_a),  32'h1F);
    checkOutput("unk_rsrc",  32'(rsrc_a),     0);
    checkOutput("unk_rdst",  32'(rdst_a),     7);
    checkOutput("unk_valid", 32'(if_valid_a), 1);
    checkOutput("unk_pc",    32'(pc_out_a),   32'h006);

    // Asynchronous reset in the middle of an LDM
    applyStimulus(0, 0, '0);
    checkOutput("ldm3_bub_valid", 32'(if_valid_a), 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_addr",  32'(imem_addr_a), 32'h010);
    checkOutput("arst_valid", 32'(if_valid_a),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0, '0);
    checkOutput("arst_next_op", 32'(op_code_a), 32'(NOT));
    checkOutput("arst_next_pc", 32'(pc_out_a),  32'h010);

    // Narrow PC: LDM in the last word takes its immediate from address 0
    rst_b = 1'b0;
    redirect_b = 1'b1;
    redirect_pc_b = 4'hF;
    applyStimulus(0, 0, '0);
    checkOutput("b_redir_addr",  32'(imem_addr_b), 32'hF);
    checkOutput("b_redir_valid", 32'(if_valid_b),  0);
    redirect_b = 1'b0;
    applyStimulus(0, 0, '0);
    checkOutput("b_bub_valid", 32'(if_valid_b),  0);
    checkOutput("b_wrap_addr", 32'(imem_addr_b), 32'h0);
    applyStimulus(0, 0, '0);
    checkOutput("b_ldm_op",    32'(op_code_b),   32'(LDM));
    checkOutput("b_ldm_imm",   32'(imm_b),       32'h1234);
    checkOutput("b_ldm_pc",    32'(pc_out_b),    32'hF);
    checkOutput("b_ldm_valid", 32'(if_valid_b),  1);
    checkOutput("b_ldm_addr",  32'(imem_addr_b), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
